// File: rtl/fp_cmac_pkg.sv
// Shared types for the iterative complex MAC: FSM states, multiplier operand select, widths.
// Pure declarations, no logic.
package fp_cmac_pkg;

   localparam int N_DEFAULT = 32;
   localparam int D_DEFAULT = 16;

   typedef enum logic [2:0] {
      IDLE,
      MUL0,
      MUL1,
      MUL2,
      DONE
   } state_t;

   // MUL0 forms P1, MUL1 forms P2, MUL2 forms P0 so the last product feeds the result directly.
   typedef enum logic [1:0] {
      SEL_P1,
      SEL_P2,
      SEL_P0
   } prod_sel_t;

   // Operands are widened by one bit so sums and negated imaginary parts cannot overflow.
   function automatic int mul_width(input int n);
      return n + 1;
   endfunction

endpackage

// File: rtl/fp_seq_mul.sv
// Signed shift-add multiplier returning floor(a*b/2^d) mod 2^n.
// Latency: load edge on start, then w iteration edges, then a one-cycle done pulse; no backpressure.
module fp_seq_mul
   import fp_cmac_pkg::*;
#(
   parameter int n = N_DEFAULT,
   parameter int d = D_DEFAULT,
   localparam int W = mul_width(n)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         done,
   output logic [n-1:0] p
);

   // Only bits below n+d influence the kept slice, so the product is held mod 2^(n+d).
   localparam int PW = n + d;
   localparam int CW = $clog2(W + 1);

   logic [PW-1:0] mcand_q;
   logic [PW-1:0] prod_q;
   logic [W-1:0]  mplier_q;
   logic [CW-1:0] cnt_q;
   logic          busy_q;
   logic          done_q;
   logic          last;

   assign last = (cnt_q == CW'(W - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         mcand_q  <= '0;
         prod_q   <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (start) begin
            mcand_q  <= PW'($signed(a));
            mplier_q <= b;
            prod_q   <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
         end else if (busy_q) begin
            // The multiplier's sign bit carries weight -2^(W-1), hence the final subtract.
            if (mplier_q[0]) prod_q <= last ? prod_q - mcand_q : prod_q + mcand_q;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
            if (last) begin
               busy_q <= 1'b0;
               done_q <= 1'b1;
            end
         end
      end
   end

   assign done = done_q;
   assign p    = prod_q[PW-1:d];

endmodule

// File: rtl/fp_iterative_complex_mac.sv
// Complex multiply / MAC (a*b or a*conj(b)) via a 3-product schedule on one sequential multiplier.
// Latency 3*(n+2)+1 cycles accept-to-send_val; send_rdy=0 holds the result and blocks new input.
module fp_iterative_complex_mac
   import fp_cmac_pkg::*;
#(
   parameter int n = N_DEFAULT,
   parameter int d = D_DEFAULT,
   localparam int W = mul_width(n)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         recv_val,
   output logic         recv_rdy,
   input  logic [n-1:0] ar,
   input  logic [n-1:0] ac,
   input  logic [n-1:0] br,
   input  logic [n-1:0] bc,
   input  logic         conj,
   input  logic         acc,
   output logic         send_val,
   input  logic         send_rdy,
   output logic [n-1:0] cr,
   output logic [n-1:0] cc
);

   state_t           state_q, state_d;
   prod_sel_t        sel;
   logic             kick_q;
   logic             acc_q;
   logic [W-1:0]     ar_q, ac_q, br_q, bcp_q, sa_q, sb_q;
   logic [W-1:0]     ar_w, ac_w, br_w, bc_w, bcp_w;
   logic [n-1:0]     p1_q, p2_q, cr_q, cc_q;
   logic [n-1:0]     re, im;
   logic             accept;
   logic             mul_start, mul_done;
   logic [W-1:0]     mul_a, mul_b;
   logic [n-1:0]     mul_p;

   assign recv_rdy = (state_q == IDLE) || ((state_q == DONE) && send_rdy);
   assign send_val = (state_q == DONE);
   assign accept   = recv_val && recv_rdy;

   assign ar_w  = W'($signed(ar));
   assign ac_w  = W'($signed(ac));
   assign br_w  = W'($signed(br));
   assign bc_w  = W'($signed(bc));
   assign bcp_w = conj ? -bc_w : bc_w;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = MUL0;
         MUL0:    if (mul_done) state_d = MUL1;
         MUL1:    if (mul_done) state_d = MUL2;
         MUL2:    if (mul_done) state_d = DONE;
         DONE:    if (send_rdy) state_d = recv_val ? MUL0 : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // The first product starts the cycle after accept; each later one starts on the previous done.
   always_comb begin
      mul_start = kick_q || (mul_done && ((state_q == MUL0) || (state_q == MUL1)));
      sel       = SEL_P0;
      if (kick_q) sel = SEL_P1;
      else if (state_q == MUL0) sel = SEL_P2;
      mul_a = sa_q;
      mul_b = sb_q;
      case (sel)
         SEL_P1: begin
            mul_a = ar_q;
            mul_b = br_q;
         end
         SEL_P2: begin
            mul_a = ac_q;
            mul_b = bcp_q;
         end
         default: ;
      endcase
   end

   fp_seq_mul #(.n(n), .d(d)) u_mul (
      .clk   (clk),
      .reset (reset),
      .start (mul_start),
      .a     (mul_a),
      .b     (mul_b),
      .done  (mul_done),
      .p     (mul_p)
   );

   assign re = p1_q - p2_q;
   assign im = mul_p - p1_q - p2_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         kick_q  <= 1'b0;
         acc_q   <= 1'b0;
         ar_q    <= '0;
         ac_q    <= '0;
         br_q    <= '0;
         bcp_q   <= '0;
         sa_q    <= '0;
         sb_q    <= '0;
         p1_q    <= '0;
         p2_q    <= '0;
         cr_q    <= '0;
         cc_q    <= '0;
      end else begin
         state_q <= state_d;
         kick_q  <= accept;
         if (accept) begin
            ar_q  <= ar_w;
            ac_q  <= ac_w;
            br_q  <= br_w;
            bcp_q <= bcp_w;
            sa_q  <= ar_w + ac_w;
            sb_q  <= br_w + bcp_w;
            acc_q <= acc;
         end
         if (mul_done && (state_q == MUL0)) p1_q <= mul_p;
         if (mul_done && (state_q == MUL1)) p2_q <= mul_p;
         if (mul_done && (state_q == MUL2)) begin
            cr_q <= acc_q ? cr_q + re : re;
            cc_q <= acc_q ? cc_q + im : im;
         end
      end
   end

   assign cr = cr_q;
   assign cc = cc_q;

endmodule
